rtc_calendar: RTL and testbench

Binary time-of-day and calendar counter (seconds through two-digit year) feeding the per-field BCD encoders of the display path. An internal prescaler derives a 1 Hz strobe from the system clock. The block advances the full carry chain with month-length and leap-year rules, and accepts a validated load of all fields through a valid/ack handshake. Every field is presented as an 8-bit binary value, directly consumable by an 8-bit-input BCD encoder.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/tick_gen.sv | 38 +++
 rtl/rtc_calendar.sv | 148 ++++++++++++++
 tb/tb_rtc_calendar.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Field limits and month-length rule shared by the calendar counter
// and the BCD display path.
package clock_pkg;

    localparam logic [7:0] SEC_MAX   = 8'd59;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] YEAR_MAX  = 8'd99;

    // Two-digit year: every year divisible by four is leap, including 00.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        logic [7:0] days;
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: days = 8'd30;
            8'd2:                    days = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 days = 8'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle advance strobe every CLK_DIV cycles
// while running; clr restarts the count so a fresh second begins.
module tick_gen #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic clr_i,
    output logic strobe_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign strobe_o = run_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = strobe_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_calendar.sv
// Binary time-of-day and calendar counter with validated bulk load.
// All outputs are registered; a load always takes priority over the advance.
module rtc_calendar
    import clock_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       run_i,
    input  logic       set_valid_i,
    input  logic [7:0] set_sec_i,
    input  logic [7:0] set_min_i,
    input  logic [7:0] set_hour_i,
    input  logic [7:0] set_day_i,
    input  logic [7:0] set_month_i,
    input  logic [7:0] set_year_i,
    output logic       set_ack_o,
    output logic       set_err_o,
    output logic [7:0] sec_o,
    output logic [7:0] min_o,
    output logic [7:0] hour_o,
    output logic [7:0] day_o,
    output logic [7:0] month_o,
    output logic [7:0] year_o,
    output logic       tick_o,
    output logic       century_o
);

    logic [7:0] sec_q, min_q, hour_q, day_q, month_q, year_q;
    logic [7:0] sec_d, min_d, hour_d, day_d, month_d, year_d;
    logic       tick_q, century_q, ack_q, err_q;
    logic       tick_d, century_d, ack_d, err_d;
    logic       loadOk;
    logic       strobe;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .run_i    (run_i),
        .clr_i    (set_valid_i && loadOk),
        .strobe_o (strobe)
    );

    always_comb begin
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        tick_d    = 1'b0;
        century_d = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        loadOk    = (set_sec_i <= SEC_MAX) && (set_min_i <= MIN_MAX) &&
                    (set_hour_i <= HOUR_MAX) && (set_month_i != 8'd0) &&
                    (set_month_i <= MONTH_MAX) && (set_year_i <= YEAR_MAX) &&
                    (set_day_i != 8'd0) &&
                    (set_day_i <= days_in_month(set_month_i, set_year_i));

        // A load request, accepted or not, swallows a coincident strobe.
        if (set_valid_i) begin
            if (loadOk) begin
                sec_d   = set_sec_i;
                min_d   = set_min_i;
                hour_d  = set_hour_i;
                day_d   = set_day_i;
                month_d = set_month_i;
                year_d  = set_year_i;
                ack_d   = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
        end else if (strobe) begin
            tick_d = 1'b1;
            if (sec_q != SEC_MAX) begin
                sec_d = sec_q + 8'd1;
            end else begin
                sec_d = 8'd0;
                if (min_q != MIN_MAX) begin
                    min_d = min_q + 8'd1;
                end else begin
                    min_d = 8'd0;
                    if (hour_q != HOUR_MAX) begin
                        hour_d = hour_q + 8'd1;
                    end else begin
                        hour_d = 8'd0;
                        if (day_q < days_in_month(month_q, year_q)) begin
                            day_d = day_q + 8'd1;
                        end else begin
                            day_d = 8'd1;
                            if (month_q != MONTH_MAX) begin
                                month_d = month_q + 8'd1;
                            end else begin
                                month_d = 8'd1;
                                if (year_q != YEAR_MAX) begin
                                    year_d = year_q + 8'd1;
                                end else begin
                                    year_d    = 8'd0;
                                    century_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sec_q     <= 8'd0;
            min_q     <= 8'd0;
            hour_q    <= 8'd0;
            day_q     <= 8'd1;
            month_q   <= 8'd1;
            year_q    <= 8'd0;
            tick_q    <= 1'b0;
            century_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            tick_q    <= tick_d;
            century_q <= century_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign sec_o     = sec_q;
    assign min_o     = min_q;
    assign hour_o    = hour_q;
    assign day_o     = day_q;
    assign month_o   = month_q;
    assign year_o    = year_q;
    assign tick_o    = tick_q;
    assign century_o = century_q;
    assign set_ack_o = ack_q;
    assign set_err_o = err_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed scoreboard bench for rtc_calendar with a 4-cycle prescaler.
module tb_rtc_calendar;

    localparam int unsigned CLK_DIV = 4;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic [7:0] day;
        logic [7:0] month;
        logic [7:0] year;
        logic       tick;
        logic       century;
        logic       ack;
        logic       err;
    } snap_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       run;
    logic       setValid;
    logic [7:0] setSec, setMin, setHour, setDay, setMonth, setYear;
    logic       setAck, setErr, tick, century;
    logic [7:0] sec, min, hour, day, month, year;

    snap_t expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    rtc_calendar #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .run_i       (run),
        .set_valid_i (setValid),
        .set_sec_i   (setSec),
        .set_min_i   (setMin),
        .set_hour_i  (setHour),
        .set_day_i   (setDay),
        .set_month_i (setMonth),
        .set_year_i  (setYear),
        .set_ack_o   (setAck),
        .set_err_o   (setErr),
        .sec_o       (sec),
        .min_o       (min),
        .hour_o      (hour),
        .day_o       (day),
        .month_o     (month),
        .year_o      (year),
        .tick_o      (tick),
        .century_o   (century)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input int s, input int mi, input int h,
                                 input int d, input int mo, input int y,
                                 input bit t, input bit c, input bit a, input bit e);
        snap_t r;
        r.sec = 8'(s);   r.min = 8'(mi);   r.hour = 8'(h);
        r.day = 8'(d);   r.month = 8'(mo); r.year = 8'(y);
        r.tick = t; r.century = c; r.ack = a; r.err = e;
        return r;
    endfunction

    task automatic applyStimulus(input bit v, input int s, input int mi, input int h,
                                 input int d, input int mo, input int y);
        setValid = v;
        setSec   = 8'(s);
        setMin   = 8'(mi);
        setHour  = 8'(h);
        setDay   = 8'(d);
        setMonth = 8'(mo);
        setYear  = 8'(y);
    endtask

    task automatic checkOutput();
        snap_t obs;
        snap_t exp;
        string tag;
        obs = {sec, min, hour, day, month, year, tick, century, setAck, setErr};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            exp = expQ.pop_front();
            tag = tagQ.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    // Expected result queued with the stimulus, compared #1 after the edge.
    task automatic stepCycle(input snap_t exp, input string tag);
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input snap_t exp, input string tag);
        for (int i = 0; i < n; i++) stepCycle(exp, tag);
    endtask

    initial begin
        rstN = 1'b0;
        run  = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "reset");
        stepCycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "reset_hold");
        rstN = 1'b1;

        for (int s = 1; s <= 3; s++) begin
            idle(CLK_DIV - 1, mk(s - 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), "pre_tick");
            stepCycle(mk(s, 0, 0, 1, 1, 0, 1, 0, 0, 0), "tick_sec");
        end

        applyStimulus(1, 59, 59, 23, 31, 12, 99);
        stepCycle(mk(59, 59, 23, 31, 12, 99, 0, 0, 1, 0), "load_eoc");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(CLK_DIV - 1, mk(59, 59, 23, 31, 12, 99, 0, 0, 0, 0), "eoc_wait");
        stepCycle(mk(0, 0, 0, 1, 1, 0, 1, 1, 0, 0), "century_wrap");

        applyStimulus(1, 59, 59, 23, 28, 2, 24);
        stepCycle(mk(59, 59, 23, 28, 2, 24, 0, 0, 1, 0), "load_leap");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(CLK_DIV - 1, mk(59, 59, 23, 28, 2, 24, 0, 0, 0, 0), "leap_wait");
        stepCycle(mk(0, 0, 0, 29, 2, 24, 1, 0, 0, 0), "leap_feb29");

        applyStimulus(1, 59, 59, 23, 28, 2, 23);
        stepCycle(mk(59, 59, 23, 28, 2, 23, 0, 0, 1, 0), "load_nonleap");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(CLK_DIV - 1, mk(59, 59, 23, 28, 2, 23, 0, 0, 0, 0), "nonleap_wait");
        stepCycle(mk(0, 0, 0, 1, 3, 23, 1, 0, 0, 0), "nonleap_mar1");

        // Fourth reject lands on the strobe cycle: that second is lost.
        applyStimulus(1, 30, 20, 10, 31, 4, 23);
        stepCycle(mk(0, 0, 0, 1, 3, 23, 0, 0, 0, 1), "rej_apr31");
        applyStimulus(1, 30, 20, 24, 15, 4, 23);
        stepCycle(mk(0, 0, 0, 1, 3, 23, 0, 0, 0, 1), "rej_hour24");
        applyStimulus(1, 30, 20, 10, 15, 0, 23);
        stepCycle(mk(0, 0, 0, 1, 3, 23, 0, 0, 0, 1), "rej_month0");
        applyStimulus(1, 30, 20, 10, 29, 2, 23);
        stepCycle(mk(0, 0, 0, 1, 3, 23, 0, 0, 0, 1), "rej_feb29_23");

        applyStimulus(1, 30, 20, 10, 29, 2, 0);
        stepCycle(mk(30, 20, 10, 29, 2, 0, 0, 0, 1, 0), "acc_feb29_00");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(CLK_DIV - 1, mk(30, 20, 10, 29, 2, 0, 0, 0, 0, 0), "acc_wait");
        stepCycle(mk(31, 20, 10, 29, 2, 0, 1, 0, 0, 0), "acc_tick");

        idle(CLK_DIV - 1, mk(31, 20, 10, 29, 2, 0, 0, 0, 0, 0), "strobe_wait");
        applyStimulus(1, 0, 0, 12, 15, 6, 50);
        stepCycle(mk(0, 0, 12, 15, 6, 50, 0, 0, 1, 0), "load_on_strobe");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(CLK_DIV - 1, mk(0, 0, 12, 15, 6, 50, 0, 0, 0, 0), "post_load_wait");
        stepCycle(mk(1, 0, 12, 15, 6, 50, 1, 0, 0, 0), "post_load_tick");

        applyStimulus(1, 5, 5, 5, 5, 5, 5);
        rstN = 1'b0;
        stepCycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "reset_over_load");
        rstN = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        idle(2, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "pre_freeze");
        run = 1'b0;
        idle(20, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "frozen");
        run = 1'b1;
        stepCycle(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "resume_pre");
        stepCycle(mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0), "resume_tick");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
